// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the 16-bit MIPS core.
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every
// datapath strobe and select. Only the state and the retired-instruction counter are
// registered. All strobes are decoded combinationally from state, opcode, zero and
// mem_ready.
//
// Parameters
//   OPC_W     opcode field width (the opcode map below assumes 3)
//   FUNCT_W   funct field width; R-type alu_op is funct passed through
//   CNT_W     retired-instruction counter width
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   opcode, funct  IR[15:13] and IR[3:0]; sampled in DECODE/EXEC/MEM/WB only
//   zero           ALU result == 0, used by BEQ/BNE in EXEC
//   mem_ready      memory completes the current request (FETCH/MEM only)
//   mem_req/we/sel memory request, write enable, address select (0 PC, 1 ALU)
//   ir_we, mdr_we  instruction / memory data register loads
//   pc_we, pc_src  PC load and source (00 PC+1, 01 branch, 10 jump)
//   alu_src_b      ALU B operand (0 rt, 1 sext(imm7))
//   alu_op         0000 ADD, 0001 SUB, otherwise funct
//   reg_we/dst     register file write and destination (0 rt, 1 rd)
//   wb_sel         write-back source (0 ALU, 1 MDR)
//   halted         core stopped by HALT
//   state          current FSM state (debug)
//   instr_cnt      retired instructions, wraps at 2^CNT_W
module mc_control_unit #(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic               ir_we,
  output logic               mdr_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               alu_src_b,
  output logic [FUNCT_W-1:0] alu_op,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               wb_sel,
  output logic               halted,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OpR    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpAddi = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpLw   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpSw   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpBeq  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OpBne  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OpJ    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OpHalt = OPC_W'(7);

  localparam logic [FUNCT_W-1:0] AluAdd = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] AluSub = FUNCT_W'(1);

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             retire;

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcSeq;
    alu_src_b = 1'b0;
    alu_op    = AluAdd;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        case (opcode)
          OpJ: begin
            pc_we   = 1'b1;
            pc_src  = PcJump;
            state_d = StFetch;
          end
          OpHalt:  state_d = StHalt;
          default: state_d = StExec;
        endcase
      end

      StExec: begin
        case (opcode)
          OpR: begin
            alu_op  = funct;
            state_d = StWb;
          end
          OpAddi: begin
            alu_src_b = 1'b1;
            state_d   = StWb;
          end
          OpLw, OpSw: begin
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          OpBeq, OpBne: begin
            alu_op  = AluSub;
            pc_src  = PcBranch;
            pc_we   = (opcode == OpBeq) ? zero : ~zero;
            state_d = StFetch;
          end
          // J and HALT never reach EXEC; recover to FETCH if they somehow do.
          default: state_d = StFetch;
        endcase
      end

      StMem: begin
        // Address is the ALU sum, so keep the ALU configured for the whole wait.
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_we    = (opcode == OpSw);
        alu_src_b = 1'b1;
        if (mem_ready) begin
          if (opcode == OpSw) begin
            state_d = StFetch;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end
      end

      StWb: begin
        reg_we  = 1'b1;
        reg_dst = (opcode == OpR);
        wb_sel  = (opcode == OpLw);
        state_d = StFetch;
      end

      StHalt: halted = 1'b1;

      default: state_d = StFetch;
    endcase

    // Reset silences the datapath immediately, not just at the next edge.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PcSeq;
      alu_src_b = 1'b0;
      alu_op    = AluAdd;
      reg_we    = 1'b0;
      reg_dst   = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
    end
  end

  // An instruction retires when it leaves a post-fetch state back to FETCH.
  always_comb begin
    retire = 1'b0;
    if (state_d == StFetch) begin
      retire = (state_q == StDecode) || (state_q == StExec) ||
               (state_q == StMem)    || (state_q == StWb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

  // A write is only meaningful as part of a request.
  a_we_needs_req: assert property (@(posedge clk) disable iff (rst) mem_we |-> mem_req);
  // A halted core must not touch memory.
  a_halt_quiet: assert property (@(posedge clk) disable iff (rst) halted |-> !mem_req);

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_we, reg_dst, wb_sel, halted;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  // Narrow-counter instance used to observe wrap-around in a few cycles.
  logic        w_mem_req, w_mem_we, w_mem_sel, w_ir_we, w_mdr_we, w_pc_we;
  logic [1:0]  w_pc_src;
  logic        w_alu_src_b;
  logic [3:0]  w_alu_op;
  logic        w_reg_we, w_reg_dst, w_wb_sel, w_halted;
  logic [2:0]  w_state;
  logic [3:0]  w_instr_cnt;

  int          checks;
  int          errors;
  logic [15:0] cnt_model;

  mc_control_unit #(.OPC_W(3), .FUNCT_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .halted(halted), .state(state), .instr_cnt(instr_cnt)
  );

  mc_control_unit #(.OPC_W(3), .FUNCT_W(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_sel(w_mem_sel),
    .ir_we(w_ir_we), .mdr_we(w_mdr_we), .pc_we(w_pc_we), .pc_src(w_pc_src),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .reg_we(w_reg_we), .reg_dst(w_reg_dst),
    .wb_sel(w_wb_sel), .halted(w_halted), .state(w_state), .instr_cnt(w_instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] strobes();
    return {mem_req, mem_we, mem_sel, ir_we, mdr_we, pc_we, pc_src, alu_src_b, alu_op,
            reg_we, reg_dst, wb_sel, halted};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt_model = '0;
  endtask

  // Runs one instruction starting in FETCH. The model is the instruction's phase
  // list (from the latency rules) plus per-instruction totals for each strobe.
  task automatic exec_instr(input logic [2:0] op, input logic [3:0] fn, input logic z,
                            input int fw, input int mw);
    logic [2:0] exp_st[$];
    logic [3:0] exec_alu;
    logic [3:0] e_alu;
    bit is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, ls, taken;
    int n_req, n_ir, n_pc, n_pc_seq, n_pc_br, n_pc_j, n_mwe, n_msel, n_mdr;
    int n_reg, n_dst, n_wbs, n_alub, n_halt;
    int e_req, e_pc, e_mwe, e_alub;
    int j;
    is_r = (op == 3'd0); is_addi = (op == 3'd1); is_lw = (op == 3'd2);
    is_sw = (op == 3'd3); is_beq = (op == 3'd4); is_bne = (op == 3'd5);
    is_j = (op == 3'd6);
    ls = is_lw || is_sw;
    taken = (is_beq && z) || (is_bne && !z);
    repeat (fw + 1) exp_st.push_back(3'd0);
    exp_st.push_back(3'd1);
    if (!is_j) exp_st.push_back(3'd2);
    if (ls) repeat (mw + 1) exp_st.push_back(3'd3);
    if (is_r || is_addi || is_lw) exp_st.push_back(3'd4);
    n_req = 0; n_ir = 0; n_pc = 0; n_pc_seq = 0; n_pc_br = 0; n_pc_j = 0; n_mwe = 0;
    n_msel = 0; n_mdr = 0; n_reg = 0; n_dst = 0; n_wbs = 0; n_alub = 0; n_halt = 0;
    exec_alu = 4'hx;
    for (int c = 0; c < exp_st.size(); c++) begin
      @(negedge clk);
      zero = z;
      if (c <= fw) begin
        opcode = 3'($urandom);
        funct = 4'($urandom);
        mem_ready = (c == fw);
      end else begin
        opcode = op;
        funct = fn;
        j = c - fw - 1;
        if (ls && j >= 2) mem_ready = (j == 2 + mw);
        else mem_ready = 1'($urandom);
      end
      #1;
      checks++;
      if (state !== exp_st[c]) begin
        errors++;
        $display("FAIL state op=%0d cycle=%0d: got %0d expected %0d", op, c, state, exp_st[c]);
      end
      if (mem_req) n_req++;
      if (ir_we) n_ir++;
      if (pc_we) n_pc++;
      if (pc_we && pc_src == 2'b00) n_pc_seq++;
      if (pc_we && pc_src == 2'b01) n_pc_br++;
      if (pc_we && pc_src == 2'b10) n_pc_j++;
      if (mem_we) n_mwe++;
      if (mem_sel) n_msel++;
      if (mdr_we) n_mdr++;
      if (reg_we) n_reg++;
      if (reg_we && reg_dst) n_dst++;
      if (reg_we && wb_sel) n_wbs++;
      if (alu_src_b) n_alub++;
      if (halted) n_halt++;
      if (exp_st[c] == 3'd2) exec_alu = alu_op;
    end
    // Back in FETCH with memory not ready: the retire count must have moved.
    if (!(op == 3'd7)) cnt_model = cnt_model + 16'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    opcode = 3'($urandom);
    #1;
    checks++;
    if (state !== 3'd0 || instr_cnt !== cnt_model) begin
      errors++;
      $display("FAIL retire op=%0d: got state %0d cnt %0d expected state 0 cnt %0d",
               op, state, instr_cnt, cnt_model);
    end
    e_req = fw + 1 + (ls ? mw + 1 : 0);
    e_pc = 1 + (is_j ? 1 : 0) + (taken ? 1 : 0);
    e_mwe = is_sw ? mw + 1 : 0;
    e_alub = is_addi ? 1 : (ls ? mw + 2 : 0);
    checks++;
    if (n_req != e_req || n_ir != 1 || n_mwe != e_mwe || n_msel != (ls ? mw + 1 : 0) ||
        n_mdr != (is_lw ? 1 : 0)) begin
      errors++;
      $display("FAIL memstrobes op=%0d: got req %0d ir %0d we %0d sel %0d mdr %0d expected %0d 1 %0d %0d %0d",
               op, n_req, n_ir, n_mwe, n_msel, n_mdr, e_req, e_mwe, ls ? mw + 1 : 0,
               is_lw ? 1 : 0);
    end
    checks++;
    if (n_pc != e_pc || n_pc_seq != 1 || n_pc_br != (taken ? 1 : 0) ||
        n_pc_j != (is_j ? 1 : 0)) begin
      errors++;
      $display("FAIL pc op=%0d z=%0d: got we %0d seq %0d br %0d j %0d expected %0d 1 %0d %0d",
               op, z, n_pc, n_pc_seq, n_pc_br, n_pc_j, e_pc, taken ? 1 : 0, is_j ? 1 : 0);
    end
    checks++;
    if (n_reg != ((is_r || is_addi || is_lw) ? 1 : 0) || n_dst != (is_r ? 1 : 0) ||
        n_wbs != (is_lw ? 1 : 0) || n_alub != e_alub || n_halt != 0) begin
      errors++;
      $display("FAIL regstrobes op=%0d: got reg %0d dst %0d wbsel %0d alub %0d halt %0d expected alub %0d",
               op, n_reg, n_dst, n_wbs, n_alub, n_halt, e_alub);
    end
    if (!is_j) begin
      e_alu = is_r ? fn : ((is_beq || is_bne) ? 4'd1 : 4'd0);
      checks++;
      if (exec_alu !== e_alu) begin
        errors++;
        $display("FAIL alu_op op=%0d: got %0d expected %0d", op, exec_alu, e_alu);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 3'd0;
    funct = 4'd0;
    zero = 1'b0;
    cnt_model = '0;
    #3;
    checks++;
    if (state !== 3'd0 || instr_cnt !== 16'd0 || strobes() !== 18'd0) begin
      errors++;
      $display("FAIL reset_early: got state %0d cnt %0d strobes %h expected 0 0 0",
               state, instr_cnt, strobes());
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || strobes() !== 18'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got state %0d strobes %h expected 0 0", state, strobes());
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_sel !== 1'b0 || ir_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got req %0d sel %0d ir %0d expected 1 0 0",
               mem_req, mem_sel, ir_we);
    end
  endtask

  task automatic test_r_add();
    exec_instr(3'd0, 4'd0, 1'b0, 0, 0);
    exec_instr(3'd0, 4'd9, 1'b1, 1, 0);
    exec_instr(3'd1, 4'd5, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    exec_instr(3'd2, 4'd3, 1'b0, 3, 3);
    exec_instr(3'd3, 4'd3, 1'b1, 0, 2);
  endtask

  task automatic test_beq();
    exec_instr(3'd4, 4'd0, 1'b1, 0, 0);
    exec_instr(3'd4, 4'd0, 1'b0, 0, 0);
    exec_instr(3'd5, 4'd0, 1'b0, 1, 0);
    exec_instr(3'd5, 4'd0, 1'b1, 0, 0);
  endtask

  task automatic test_j_halt();
    exec_instr(3'd6, 4'd0, 1'b0, 0, 0);
    @(negedge clk);
    opcode = 3'($urandom);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || ir_we !== 1'b1) begin
      errors++;
      $display("FAIL halt_fetch: got state %0d ir %0d expected 0 1", state, ir_we);
    end
    @(negedge clk);
    opcode = 3'd7;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd1 || halted !== 1'b0 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL halt_decode: got state %0d halted %0d pc_we %0d expected 1 0 0",
               state, halted, pc_we);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = i[0];
      #1;
      checks++;
      if (state !== 3'd5 || strobes() !== 18'd1 || instr_cnt !== cnt_model) begin
        errors++;
        $display("FAIL halt_hold cycle=%0d: got state %0d strobes %h cnt %0d expected 5 1 %0d",
                 i, state, strobes(), instr_cnt, cnt_model);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    exec_instr(3'd0, 4'd2, 1'b0, 0, 0);
    @(negedge clk);
    opcode = 3'($urandom);
    mem_ready = 1'b1;
    @(negedge clk);
    opcode = 3'd3;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_sel !== 1'b1) begin
      errors++;
      $display("FAIL sw_mem: got state %0d req %0d we %0d sel %0d expected 3 1 1 1",
               state, mem_req, mem_we, mem_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || strobes() !== 18'd0 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_rst: got state %0d strobes %h cnt %0d expected 0 0 0",
               state, strobes(), instr_cnt);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || strobes() !== 18'd0) begin
      errors++;
      $display("FAIL async_rst_edge: got state %0d strobes %h expected 0 0", state, strobes());
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    cnt_model = '0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1 || mem_sel !== 1'b0 || mem_we !== 1'b0 ||
        instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_rst_fetch: got state %0d req %0d sel %0d we %0d cnt %0d expected 0 1 0 0 0",
               state, mem_req, mem_sel, mem_we, instr_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) exec_instr(3'd6, 4'($urandom), 1'($urandom), 0, 0);
    checks++;
    if (w_instr_cnt !== 4'hF) begin
      errors++;
      $display("FAIL wrap_max: got %0d expected 15", w_instr_cnt);
    end
    exec_instr(3'd6, 4'd0, 1'b0, 0, 0);
    checks++;
    if (w_instr_cnt !== 4'h0 || instr_cnt !== 16'd16) begin
      errors++;
      $display("FAIL wrap_zero: got %0d wide %0d expected 0 16", w_instr_cnt, instr_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      exec_instr(3'($urandom_range(0, 6)), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_r_add();
    test_lw_wait();
    test_beq();
    test_j_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
